// File: rtl/score_pkg.sv
// Shared types, limits and BCD conversion helpers for the two-digit HUD score.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_SCORE = 99;
  localparam int MAX_EVENT = 9;

  typedef enum logic {IDLE, BLINK} blink_state_t;

  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = 4'(value / 7'd10);
    ones = 4'(value % 7'd10);
    return {tens, ones};
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
    return 7'({3'b000, tens} * 7'd10 + {3'b000, ones});
  endfunction

  // Event sizes above one decimal digit are capped so a single event never exceeds 9 points.
  function automatic bcd_digit_t clamp_event(input logic [3:0] value);
    return (value > 4'(MAX_EVENT)) ? 4'(MAX_EVENT) : value;
  endfunction

endpackage

// File: rtl/score_blink_timer.sv
// Blink gate for the score digits: a burst of BLINK_TOGGLES half-periods
// started by a milestone, cancelled by clear.
module score_blink_timer
  import score_pkg::*;
#(
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic cancel,
  output logic display_on
);

  blink_state_t state_q;
  logic [23:0]  halfCnt_q;
  logic [3:0]   toggleCnt_q;
  logic         displayOn_q;

  // A new start during a burst restarts it from the beginning with the digits visible.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      halfCnt_q   <= '0;
      toggleCnt_q <= '0;
      displayOn_q <= 1'b1;
    end else if (cancel) begin
      state_q     <= IDLE;
      halfCnt_q   <= '0;
      toggleCnt_q <= '0;
      displayOn_q <= 1'b1;
    end else if (start) begin
      state_q     <= BLINK;
      halfCnt_q   <= '0;
      toggleCnt_q <= '0;
      displayOn_q <= 1'b1;
    end else if (state_q == BLINK) begin
      if (halfCnt_q == 24'(BLINK_HALF - 1)) begin
        halfCnt_q   <= '0;
        displayOn_q <= ~displayOn_q;
        if (toggleCnt_q == 4'(BLINK_TOGGLES - 1)) begin
          state_q     <= IDLE;
          toggleCnt_q <= '0;
        end else begin
          toggleCnt_q <= toggleCnt_q + 4'd1;
        end
      end else begin
        halfCnt_q <= halfCnt_q + 24'd1;
      end
    end
  end

  assign display_on = displayOn_q;

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score register clamped to 00..99, with sticky saturation flags,
// a tens-digit milestone pulse and the blink gate for the digit renderer.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6,
  parameter int INIT_SCORE    = 0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       add_req,
  input  logic [3:0] add_val,
  input  logic       sub_req,
  input  logic [3:0] sub_val,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       sat_hi,
  output logic       sat_lo,
  output logic       milestone,
  output logic       display_on
);

  localparam logic [7:0] INIT_BCD = bin_to_bcd2(7'(INIT_SCORE));

  bcd_digit_t        digit1_q, digit1_d;
  bcd_digit_t        digit2_q, digit2_d;
  logic              satHi_q, satHi_d;
  logic              satLo_q, satLo_d;
  logic              milestone_q, milestone_d;
  logic [6:0]        curVal;
  logic [6:0]        clampVal;
  logic signed [8:0] nextVal;
  logic [7:0]        nextBcd;

  // The score is handled in binary for the signed add/sub and converted back to BCD.
  always_comb begin
    curVal   = bcd2_to_bin(digit1_q, digit2_q);
    nextVal  = 9'(curVal)
             + 9'(add_req ? clamp_event(add_val) : 4'd0)
             - 9'(sub_req ? clamp_event(sub_val) : 4'd0);
    satHi_d  = satHi_q;
    satLo_d  = satLo_q;
    clampVal = nextVal[6:0];
    if (nextVal[8]) begin
      clampVal = 7'd0;
      satLo_d  = 1'b1;
    end else if (nextVal[7:0] > 8'(MAX_SCORE)) begin
      clampVal = 7'(MAX_SCORE);
      satHi_d  = 1'b1;
    end
    nextBcd     = bin_to_bcd2(clampVal);
    digit1_d    = nextBcd[7:4];
    digit2_d    = nextBcd[3:0];
    milestone_d = (digit1_d > digit1_q);
    if (clear) begin
      digit1_d    = INIT_BCD[7:4];
      digit2_d    = INIT_BCD[3:0];
      satHi_d     = 1'b0;
      satLo_d     = 1'b0;
      milestone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit1_q    <= INIT_BCD[7:4];
      digit2_q    <= INIT_BCD[3:0];
      satHi_q     <= 1'b0;
      satLo_q     <= 1'b0;
      milestone_q <= 1'b0;
    end else begin
      digit1_q    <= digit1_d;
      digit2_q    <= digit2_d;
      satHi_q     <= satHi_d;
      satLo_q     <= satLo_d;
      milestone_q <= milestone_d;
    end
  end

  // The burst starts on the same edge that registers the milestone.
  score_blink_timer #(
    .BLINK_HALF   (BLINK_HALF),
    .BLINK_TOGGLES(BLINK_TOGGLES)
  ) u_blink (
    .clk       (clk),
    .resetN    (resetN),
    .start     (milestone_d),
    .cancel    (clear),
    .display_on(display_on)
  );

  assign digit1    = digit1_q;
  assign digit2    = digit2_q;
  assign sat_hi    = satHi_q;
  assign sat_lo    = satLo_q;
  assign milestone = milestone_q;

endmodule
